// File: rtl/trace_monitor_pkg.sv
// Shared constants for the per-core trace monitor: the l.nop opcode and the
// simulation-control K codes carried in the low half of the instruction.
package trace_monitor_pkg;

    localparam logic [7:0]  NOP_OPCODE = 8'h15;

    localparam logic [15:0] NOP_EXIT   = 16'h0001;
    localparam logic [15:0] NOP_REPORT = 16'h0002;
    localparam logic [15:0] NOP_PUTC   = 16'h0004;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXIT,
        EV_REPORT,
        EV_PUTC
    } nop_event_e;

    function automatic nop_event_e decode_nop(input logic valid, input logic [31:0] insn);
        nop_event_e ev;
        ev = EV_NONE;
        if (valid && insn[31:24] == NOP_OPCODE) begin
            case (insn[15:0])
                NOP_EXIT:   ev = EV_EXIT;
                NOP_REPORT: ev = EV_REPORT;
                NOP_PUTC:   ev = EV_PUTC;
                default:    ev = EV_NONE;
            endcase
        end
        return ev;
    endfunction

endpackage

// File: rtl/r3_shadow_reg.sv
// Shadow copy of one GPR, updated from the retired-instruction write-back
// stream whenever that register is the destination.
module r3_shadow_reg
    import trace_monitor_pkg::*;
#(
    parameter int unsigned REG_IDX = 3
) (
    input  logic        clk,
    input  logic        rst_sys,
    input  logic        valid,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    always_comb begin
        value_d = value_q;
        if (valid && we && addr == 5'(REG_IDX)) begin
            value_d = data;
        end
    end

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/core_trace_monitor.sv
// Observation-only trace monitor for one core: shadows r3, turns l.nop K
// control codes into exit/report/putc events, counts retired instructions.
module core_trace_monitor
    import trace_monitor_pkg::*;
#(
    parameter int ID             = 0,
    parameter int TERM_CROSS_NUM = 4,
    parameter int ENABLE_TRACE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_sys,
    input  logic                      enable,
    input  logic [31:0]               wb_pc,
    input  logic [31:0]               wb_insn,
    input  logic                      wb_we,
    input  logic [4:0]                wb_reg,
    input  logic [31:0]               wb_data,
    input  logic [TERM_CROSS_NUM-1:0] termination_all,
    output logic [31:0]               r3,
    output logic                      termination,
    output logic [31:0]               exit_code,
    output logic                      putc_valid,
    output logic [7:0]                putc_char,
    output logic                      report_valid,
    output logic [31:0]               report_data,
    output logic                      trace_valid,
    output logic [31:0]               trace_pc,
    output logic [31:0]               trace_insn,
    output logic [31:0]               insn_count,
    output logic                      all_terminated,
    output logic [31:0]               id
);

    logic [31:0] r3_value;
    nop_event_e  nop_ev;

    logic        termination_q, termination_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic        putc_valid_q, putc_valid_d;
    logic [7:0]  putc_char_q, putc_char_d;
    logic        report_valid_q, report_valid_d;
    logic [31:0] report_data_q, report_data_d;
    logic        trace_valid_q, trace_valid_d;
    logic [31:0] trace_pc_q, trace_pc_d;
    logic [31:0] trace_insn_q, trace_insn_d;
    logic [31:0] insn_count_q, insn_count_d;

    r3_shadow_reg #(
        .REG_IDX (3)
    ) u_r3_shadow (
        .clk     (clk),
        .rst_sys (rst_sys),
        .valid   (enable),
        .we      (wb_we),
        .addr    (wb_reg),
        .data    (wb_data),
        .value   (r3_value)
    );

    assign nop_ev = decode_nop(enable, wb_insn);

    // Decode reads the registered r3, so a NOP always sees the value from
    // before this cycle's write-back; events are muted once this core exits.
    always_comb begin
        termination_d  = termination_q;
        exit_code_d    = exit_code_q;
        putc_valid_d   = 1'b0;
        putc_char_d    = putc_char_q;
        report_valid_d = 1'b0;
        report_data_d  = report_data_q;
        trace_valid_d  = (ENABLE_TRACE != 0) && enable;
        trace_pc_d     = trace_pc_q;
        trace_insn_d   = trace_insn_q;
        insn_count_d   = insn_count_q;

        if (enable) begin
            trace_pc_d   = wb_pc;
            trace_insn_d = wb_insn;
            insn_count_d = insn_count_q + 32'd1;
        end

        if (!termination_q) begin
            case (nop_ev)
                EV_EXIT: begin
                    termination_d = 1'b1;
                    exit_code_d   = r3_value;
                end
                EV_REPORT: begin
                    report_valid_d = 1'b1;
                    report_data_d  = r3_value;
                end
                EV_PUTC: begin
                    putc_valid_d = 1'b1;
                    putc_char_d  = r3_value[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            termination_q  <= 1'b0;
            exit_code_q    <= '0;
            putc_valid_q   <= 1'b0;
            putc_char_q    <= '0;
            report_valid_q <= 1'b0;
            report_data_q  <= '0;
            trace_valid_q  <= 1'b0;
            trace_pc_q     <= '0;
            trace_insn_q   <= '0;
            insn_count_q   <= '0;
        end else begin
            termination_q  <= termination_d;
            exit_code_q    <= exit_code_d;
            putc_valid_q   <= putc_valid_d;
            putc_char_q    <= putc_char_d;
            report_valid_q <= report_valid_d;
            report_data_q  <= report_data_d;
            trace_valid_q  <= trace_valid_d;
            trace_pc_q     <= trace_pc_d;
            trace_insn_q   <= trace_insn_d;
            insn_count_q   <= insn_count_d;
        end
    end

    assign r3             = r3_value;
    assign termination    = termination_q;
    assign exit_code      = exit_code_q;
    assign putc_valid     = putc_valid_q;
    assign putc_char      = putc_char_q;
    assign report_valid   = report_valid_q;
    assign report_data    = report_data_q;
    assign trace_valid    = trace_valid_q;
    assign trace_pc       = trace_pc_q;
    assign trace_insn     = trace_insn_q;
    assign insn_count     = insn_count_q;
    assign all_terminated = &termination_all;
    assign id             = 32'(ID);

endmodule

// File: tb/tb_core_trace_monitor.sv
// Directed and randomized checks of core_trace_monitor against a
// cycle-level reference model of the trace-stream rules.
module tb_core_trace_monitor;

   localparam int TB_ID = 2;

   logic        clk = 1'b0;
   logic        rst_sys;
   logic        enable;
   logic [31:0] wbPc;
   logic [31:0] wbInsn;
   logic        wbWe;
   logic [4:0]  wbReg;
   logic [31:0] wbData;
   logic [3:0]  terminationAll;

   logic [31:0] r3;
   logic        termination;
   logic [31:0] exitCode;
   logic        putcValid;
   logic [7:0]  putcChar;
   logic        reportValid;
   logic [31:0] reportData;
   logic        traceValid;
   logic [31:0] tracePc;
   logic [31:0] traceInsn;
   logic [31:0] insnCount;
   logic        allTerminated;
   logic [31:0] idOut;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state: what each registered output should hold after the last edge
   logic [31:0] mR3;
   logic        mTerm;
   logic [31:0] mExit;
   logic        mPutcV;
   logic [7:0]  mPutcC;
   logic        mRepV;
   logic [31:0] mRepD;
   logic        mTraceV;
   logic [31:0] mTracePc;
   logic [31:0] mTraceInsn;
   logic [31:0] mCount;

   core_trace_monitor #(
      .ID             (TB_ID),
      .TERM_CROSS_NUM (4),
      .ENABLE_TRACE   (1)
   ) dut (
      .clk             (clk),
      .rst_sys         (rst_sys),
      .enable          (enable),
      .wb_pc           (wbPc),
      .wb_insn         (wbInsn),
      .wb_we           (wbWe),
      .wb_reg          (wbReg),
      .wb_data         (wbData),
      .termination_all (terminationAll),
      .r3              (r3),
      .termination     (termination),
      .exit_code       (exitCode),
      .putc_valid      (putcValid),
      .putc_char       (putcChar),
      .report_valid    (reportValid),
      .report_data     (reportData),
      .trace_valid     (traceValid),
      .trace_pc        (tracePc),
      .trace_insn      (traceInsn),
      .insn_count      (insnCount),
      .all_terminated  (allTerminated),
      .id              (idOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mR3 = '0; mTerm = 1'b0; mExit = '0; mPutcV = 1'b0; mPutcC = '0;
      mRepV = 1'b0; mRepD = '0; mTraceV = 1'b0; mTracePc = '0; mTraceInsn = '0; mCount = '0;
   endtask

   task automatic checkAll(input string phase);
      checkOutput({phase, ".r3"},          r3,                    mR3);
      checkOutput({phase, ".termination"}, 32'(termination),      32'(mTerm));
      checkOutput({phase, ".exit_code"},   exitCode,              mExit);
      checkOutput({phase, ".putc_valid"},  32'(putcValid),        32'(mPutcV));
      checkOutput({phase, ".putc_char"},   32'(putcChar),         32'(mPutcC));
      checkOutput({phase, ".report_valid"},32'(reportValid),      32'(mRepV));
      checkOutput({phase, ".report_data"}, reportData,            mRepD);
      checkOutput({phase, ".trace_valid"}, 32'(traceValid),       32'(mTraceV));
      checkOutput({phase, ".trace_pc"},    tracePc,               mTracePc);
      checkOutput({phase, ".trace_insn"},  traceInsn,             mTraceInsn);
      checkOutput({phase, ".insn_count"},  insnCount,             mCount);
      checkOutput({phase, ".all_term"},    32'(allTerminated),    32'(&terminationAll));
      checkOutput({phase, ".id"},          idOut,                 32'(TB_ID));
   endtask

   // Drive one retirement slot, advance one edge, update the model and check
   task automatic applyStimulus(input string phase, input logic en, input logic [31:0] insn,
                                input logic we, input logic [4:0] rg, input logic [31:0] data);
      logic [31:0] pc;
      logic [15:0] k;
      pc     = $urandom;
      enable = en; wbPc = pc; wbInsn = insn; wbWe = we; wbReg = rg; wbData = data;
      @(posedge clk);
      mPutcV  = 1'b0;
      mRepV   = 1'b0;
      mTraceV = en;
      if (en) begin
         mCount     = mCount + 1;
         mTracePc   = pc;
         mTraceInsn = insn;
         k = insn[15:0];
         if (insn[31:24] == 8'h15 && !mTerm) begin
            if (k == 16'h0001) begin
               mTerm = 1'b1;
               mExit = mR3;
            end else if (k == 16'h0002) begin
               mRepV = 1'b1;
               mRepD = mR3;
            end else if (k == 16'h0004) begin
               mPutcV = 1'b1;
               mPutcC = mR3[7:0];
            end
         end
         if (we && rg == 5'd3) mR3 = data;
      end
      #1;
      checkAll(phase);
   endtask

   task automatic midClockReset(input string phase);
      enable = 1'b0; wbWe = 1'b0;
      @(negedge clk);
      #2;
      rst_sys = 1'b1;
      #1;
      modelReset();
      checkAll(phase);
      #1;
      rst_sys = 1'b0;
      @(posedge clk);
      mTraceV = 1'b0;
      #1;
   endtask

   task automatic randomStep(input string phase);
      logic        en;
      logic [31:0] insn;
      int          sel;
      en  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      case (sel)
         0:       insn = ($urandom_range(0, 7) == 0) ? 32'h15000001 : 32'h15000003;
         1, 2:    insn = 32'h15000002 | ({8'h0, 8'($urandom)} << 16);
         3, 4, 5: insn = 32'h15000004;
         6:       insn = {8'h15, 8'($urandom), 16'($urandom)};
         default: insn = $urandom;
      endcase
      applyStimulus(phase, en, insn, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
   endtask

   initial begin
      rst_sys = 1'b1; enable = 1'b0; wbPc = '0; wbInsn = '0; wbWe = 1'b0;
      wbReg = '0; wbData = '0; terminationAll = 4'b0000;
      modelReset();
      #12;
      checkAll("reset");
      @(negedge clk);
      rst_sys = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] shadow write and putc");
      applyStimulus("wr_r3", 1'b1, 32'h0000_0000, 1'b1, 5'd3, 32'h48);
      applyStimulus("putc", 1'b1, 32'h1500_0004, 1'b0, 5'd0, 32'h0);
      checkOutput("putc_pulse", 32'(putcValid), 32'd1);
      checkOutput("putc_char_48", 32'(putcChar), 32'h48);
      applyStimulus("idle", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("putc_one_cycle", 32'(putcValid), 32'd0);

      $display("[TB] back-to-back putc");
      applyStimulus("putc_b2b0", 1'b1, 32'h1500_0004, 1'b0, 5'd0, 32'h0);
      applyStimulus("putc_b2b1", 1'b1, 32'h1500_0004, 1'b1, 5'd3, 32'h61);
      checkOutput("putc_b2b_old_r3", 32'(putcChar), 32'h48);
      applyStimulus("putc_b2b2", 1'b1, 32'h1500_0004, 1'b0, 5'd0, 32'h0);
      checkOutput("putc_b2b_new_r3", 32'(putcChar), 32'h61);

      $display("[TB] report");
      applyStimulus("wr_r3", 1'b1, 32'h0000_0000, 1'b1, 5'd3, 32'hDEADBEEF);
      applyStimulus("report", 1'b1, 32'h1500_0002, 1'b0, 5'd0, 32'h0);
      checkOutput("report_pulse", 32'(reportValid), 32'd1);
      checkOutput("report_data", reportData, 32'hDEADBEEF);
      applyStimulus("wr_r5", 1'b1, 32'h0000_0000, 1'b1, 5'd5, 32'h1234);
      checkOutput("r5_not_r3", r3, 32'hDEADBEEF);
      checkOutput("report_one_cycle", 32'(reportValid), 32'd0);

      $display("[TB] exit");
      applyStimulus("wr_r3", 1'b1, 32'h0000_0000, 1'b1, 5'd3, 32'd7);
      applyStimulus("exit", 1'b1, 32'h1500_0001, 1'b0, 5'd0, 32'h0);
      checkOutput("exit_term", 32'(termination), 32'd1);
      checkOutput("exit_code_7", exitCode, 32'd7);
      applyStimulus("putc_after", 1'b1, 32'h1500_0004, 1'b0, 5'd0, 32'h0);
      checkOutput("putc_muted", 32'(putcValid), 32'd0);
      applyStimulus("wr_r3_9", 1'b1, 32'h0000_0000, 1'b1, 5'd3, 32'd9);
      applyStimulus("exit2", 1'b1, 32'h1500_0001, 1'b0, 5'd0, 32'h0);
      checkOutput("exit_code_kept", exitCode, 32'd7);
      checkOutput("r3_after_term", r3, 32'd9);

      $display("[TB] mid-clock reset clears termination");
      midClockReset("midreset");
      checkOutput("term_cleared", 32'(termination), 32'd0);

      $display("[TB] non-control nop and instruction count");
      for (int i = 0; i < 10; i++) begin
         applyStimulus("count", 1'b1, (i == 4) ? 32'h1500_0003 : 32'h1234_0000 + 32'(i), 1'b0, 5'd0, 32'h0);
         checkOutput("no_putc", 32'(putcValid), 32'd0);
         if (i % 3 == 0) applyStimulus("gap", 1'b0, 32'h1500_0004, 1'b0, 5'd0, 32'h0);
      end
      checkOutput("insn_count_10", insnCount, 32'd10);

      $display("[TB] global done");
      terminationAll = 4'b0111;
      #1;
      checkOutput("all_term_0111", 32'(allTerminated), 32'd0);
      terminationAll = 4'b1111;
      #1;
      checkOutput("all_term_1111", 32'(allTerminated), 32'd1);
      terminationAll = 4'b0000;
      @(posedge clk);
      #1;

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) randomStep("rand1");
      midClockReset("rand_reset");
      for (int i = 0; i < 300; i++) randomStep("rand2");

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
